// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential MULT/MULTU unit.
// Holds the FSM state enum, iteration count and product width.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } mult_state_t;

  localparam int MULT_ITER = 32;
  localparam int PROD_W    = 64;

endpackage

// File: rtl/mult_negate64.sv
// Conditional two's-complement of a product-width value.
// Ports: neg (negate when 1), x (input), y (neg ? -x : x).
module mult_negate64
  import mult_pkg::*;
#(
  parameter int W = PROD_W
) (
  input  logic         neg,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  always_comb begin
    y = x;
    if (neg) y = (~x) + W'(1);
  end

endmodule

// File: rtl/mult_unit.sv
// Radix-2 shift-and-add multiplier for MULT/MULTU, 34-cycle latency.
// Ports: clk, reset (async high), start, Sign, A, B -> busy, done, HI, LO.
// Optional: MULT_EARLY_EXIT_EN ends RUN once the multiplier is exhausted.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mult_state_t     state;
  logic            neg;
  logic [PW-1:0]   mcand;
  logic [PW-1:0]   acc;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;

  logic [WIDTH-1:0] amag;
  logic [WIDTH-1:0] bmag;
  logic [PW-1:0]    prod;
  logic             fin;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  always_comb begin
    amag = A;
    bmag = B;
    if (Sign && A[WIDTH-1]) amag = (~A) + WIDTH'(1);
    if (Sign && B[WIDTH-1]) bmag = (~B) + WIDTH'(1);
  end

  mult_negate64 #(.W(PW)) u_neg (
    .neg (neg),
    .x   (acc),
    .y   (prod)
  );

`ifdef MULT_EARLY_EXIT_EN
  // multiplier empty after this shift: no further adds can occur
  assign fin = (cnt == LAST) || (mplier[WIDTH-1:1] == '0);
`else
  assign fin = (cnt == LAST);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      neg    <= 1'b0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            neg    <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
            mcand  <= {{WIDTH{1'b0}}, amag};
            mplier <= bmag;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (fin) state <= SIGN;
        end
        SIGN: begin
          {HI, LO} <= prod;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit.
// Latency expectations follow MULT_EARLY_EXIT_EN when defined.
module tb_mult_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        Sign;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks;
  int errors;

  mult_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .Sign  (Sign),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // msb = index of highest set bit of |B| (0 when |B| is 0 or 1)
  function automatic int lat(input int msb);
`ifdef MULT_EARLY_EXIT_EN
    return 3 + msb;
`else
    return 34;
`endif
  endfunction

  // Launch one multiply and wait for done; now=1 means start
  // is driven in the current cycle (back-to-back on done).
  // inj>0 pulses a stray start at that cycle while busy.
  task automatic run(input string tag, input bit now,
                     input bit sg, input logic [31:0] a,
                     input logic [31:0] b, input int inj,
                     input int elat, input logic [31:0] ehi,
                     input logic [31:0] elo);
    int n;
    if (!now) @(negedge clk);
    Sign  = sg;
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 32'h0bad_0bad;
    B     = 32'h0000_0002;
    Sign  = ~sg;
    n = 1;
    chk({tag, "_busy1"}, 64'(busy), 64'd1);
    while (!done && n < 100) begin
      if (n == inj) begin
        start = 1'b1;
        A     = 32'd2;
        B     = 32'd3;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(elat));
    chk({tag, "_busy0"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(HI), 64'(ehi));
    chk({tag, "_lo"}, 64'(LO), 64'(elo));
  endtask

  initial begin
    int dc;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    Sign   = 1'b0;
    A      = '0;
    B      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run("u_ff", 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
        lat(31), 32'hFFFF_FFFE, 32'h0000_0001);
    run("s_m3x5", 0, 1, 32'hFFFF_FFFD, 32'd5, 0,
        lat(2), 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("u_m3x5", 0, 0, 32'hFFFF_FFFD, 32'd5, 0,
        lat(2), 32'h0000_0004, 32'hFFFF_FFF1);
    run("s_minmin", 0, 1, 32'h8000_0000, 32'h8000_0000, 0,
        lat(31), 32'h4000_0000, 32'h0000_0000);
    run("s_minx1", 0, 1, 32'h8000_0000, 32'd1, 0,
        lat(0), 32'hFFFF_FFFF, 32'h8000_0000);

    run("ign", 0, 0, 32'h0001_0000, 32'h0001_0000, 10,
        lat(16), 32'h0000_0001, 32'h0000_0000);
    run("b2b", 1, 0, 32'd6, 32'd7, 0,
        lat(2), 32'h0000_0000, 32'h0000_002A);
    @(posedge clk);
    #1;
    chk("hold_done0", 64'(done), 64'd0);
    chk("hold_lo", {HI, LO}, 64'h2A);

    // reset during cycle 15 of a long multiply
    @(negedge clk);
    Sign  = 1'b0;
    A     = 32'd3;
    B     = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dc = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) dc++;
    end
    chk("mrst_nodone", 64'(dc), 64'd0);

    run("s_m1xm1", 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
        lat(0), 32'h0000_0000, 32'h0000_0001);
    run("u_7x16", 0, 0, 32'd7, 32'h0000_0010, 0,
        lat(4), 32'h0000_0000, 32'h0000_0070);
    run("u_bz", 0, 0, 32'h1234_5678, 32'd0, 0,
        lat(0), 32'h0000_0000, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
